multi_cycle_mips: RTL and testbench
===================================

// Module: multi_cycle_mips
// PURPOSE
//  Multi-cycle MIPS-I subset core: one instruction executes over 3-5 states, sharing one ALU and one
//  register file. Both the instruction and data ports use req/ready handshakes, so memories may insert
//  wait states. The core sits between instmem/datamem and reports retirement and trap status to the testbench.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value loaded at reset
//  ADDR_W      32             width of inst_addr/data_addr (PC[ADDR_W-1:0]); 8..32
//  EN_SLT      1              1: slt/sltu decode legally; 0: they trap as illegal
// PORTS
//  clk         in   1       rising-edge clock
//  rst_n       in   1       reset, asynchronous, active-low
//  inst_req    out  1       instruction fetch request
//  inst_addr   out  ADDR_W  fetch address (word aligned)
//  inst        in   32      instruction word, valid when inst_ready=1
//  inst_ready  in   1       fetch completes in a cycle where inst_req=1 and inst_ready=1
//  data_req    out  1       data access request
//  data_wr     out  1       1=store, 0=load; valid while data_req=1
//  data_addr   out  ADDR_W  load/store byte address
//  data_out    out  32      store data (rt)
//  data_in     in   32      load data, sampled when data_req=1 and data_ready=1
//  data_ready  in   1       data access completes this cycle
//  retire      out  1       1-cycle pulse when an instruction commits
//  trap        out  1       sticky; set on illegal opcode or misaligned lw/sw
// BEHAVIOUR
//  Reset (async assert, sync deassert): state=FETCH, PC=RESET_PC, all 32 GPRs=0, every output=0.
//   Assertion mid-instruction aborts it, drops req immediately, and commits no register or PC write.
//  Supported: add/addu/sub/subu/and/or/xor/nor/slt/sltu (R), addi/addiu/andi/ori/lui/slti, lw, sw, beq, bne, j.
//   No overflow exceptions: add behaves as addu. Logic immediates zero-extend; all others sign-extend.
//  FSM: FETCH -> DECODE -> EXEC -> {FETCH | MEM | WB}; MEM -> {WB | FETCH}; any -> TRAP on error.
//   FETCH : inst_req=1, inst_addr=PC. Holds until inst_ready; then IR<=inst and PC<=PC+4 (mod 2^32).
//   DECODE: reads rs/rt into A/B. Illegal opcode/funct -> TRAP.
//   EXEC  : ALU op. beq/bne: if taken, PC<=PC+(sext(imm)<<2); retire; go to FETCH. j: PC<={PC[31:28],tgt,2'b00};
//           retire; go to FETCH. lw/sw: address=A+sext(imm); if addr[1:0]!=0 -> TRAP, else go to MEM.
//           ALU ops -> WB.
//   MEM   : data_req=1; address and data_wr held stable until data_ready. sw: retire, go to FETCH.
//           lw: latch data_in, go to WB.
//   WB    : write rd (R-type) or rt (imm/lw); retire; go to FETCH. Writes to $0 are discarded; $0 always reads 0.
//   TRAP  : trap=1, no requests, no retire; stays here until reset.
//  Latency at zero wait states: branch/j 3 cycles, ALU 4, sw 4, lw 5. Each wait cycle adds exactly 1.
//  Outputs are registered; inst_req/data_req fall in the cycle after the ready handshake.
//  Register file: 2 async read ports, 1 sync write port. A WB write is visible to the next DECODE.
// STRUCTURE
//  mips_pkg: opcode/funct localparams, state enum, alu_op_t enum, sext16/zext16 functions.
//  Sub-module mips_alu (combinational; alu_op_t, a, b -> y, zero). Register file and FSM are inline.
// TESTING
//  1. Reset: rst_n=0 -> all outputs 0; after release inst_req=1 and inst_addr=RESET_PC on the first edge.
//  2. addi $1,$0,5 ; addi $2,$0,-3 ; add $3,$1,$2 -> $3=2; 3 retire pulses; 12 cycles at zero wait.
//  3. sw $3,8($0) ; lw $4,8($0) with data_ready delayed 3 cycles -> store data 2 at addr 8; $4=2;
//     data_addr stable throughout the wait; lw takes 8 cycles.
//  4. beq $1,$1,-1 -> PC loops at the same address; bne not taken -> PC+4; j 0x40 -> inst_addr=0x100.
//  5. Errors: opcode 6'h3F -> trap=1, no further inst_req; lw $5,2($0) -> trap, $5 unchanged, no data_req.
//  6. addi $0,$0,7 then add $6,$0,$0 -> $6=0. Reset pulsed during MEM wait -> data_req drops async;
//     no GPR change; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings, FSM states and ALU operations for the multi-cycle MIPS core.
// Holds the immediate-extension helpers used by decode.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU, ALU_LUI
  } alu_op_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU shared by every instruction class; zero flag drives beq/bne.
// No internal state, result valid in the same cycle.
module mips_alu
  import mips_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        zero
);

  always_comb begin
    y = 32'h0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_NOR:  y = ~(a | b);
      ALU_SLT:  y = {31'h0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'h0, a < b};
      ALU_LUI:  y = {b[15:0], 16'h0000};
      default:  y = 32'h0;
    endcase
  end

  assign zero = (y == 32'h0);

endmodule

// File: rtl/multi_cycle_mips.sv
// Multi-cycle MIPS-I subset core: FETCH/DECODE/EXEC/MEM/WB over one ALU and a 2R1W register file.
// Fetch and data ports stall on req/ready; all outputs are registered, trap is sticky until reset.
module multi_cycle_mips
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32,
  parameter bit          EN_SLT   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [31:0]       inst,
  input  logic              inst_ready,
  output logic              data_req,
  output logic              data_wr,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_out,
  input  logic [31:0]       data_in,
  input  logic              data_ready,
  output logic              retire,
  output logic              trap
);

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0]       alu_q, alu_d, mdr_q, mdr_d, data_out_q, data_out_d;
  logic [ADDR_W-1:0] inst_addr_q, inst_addr_d, data_addr_q, data_addr_d;
  logic              inst_req_q, inst_req_d, data_req_q, data_req_d;
  logic              data_wr_q, data_wr_d, retire_q, retire_d, trap_q, trap_d;
  logic [31:0]       rf_q [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [31:0] imm_sext, imm_zext, alu_b, alu_y;
  logic        alu_zero, unused_shamt;

  assign opcode       = ir_q[31:26];
  assign rs           = ir_q[25:21];
  assign rt           = ir_q[20:16];
  assign rd           = ir_q[15:11];
  assign funct        = ir_q[5:0];
  assign imm          = ir_q[15:0];
  assign unused_shamt = ^ir_q[10:6];
  assign imm_sext     = sext16(imm);
  assign imm_zext     = zext16(imm);

  alu_op_t dec_op;
  logic    dec_legal, dec_use_imm, dec_zext, dec_dest_rd;
  logic    dec_branch, dec_j, dec_lw, dec_sw;

  // Decode is re-evaluated from IR every cycle; only DECODE acts on legality.
  always_comb begin
    dec_op = ALU_ADD;  dec_legal = 1'b1;  dec_use_imm = 1'b1;  dec_zext = 1'b0;
    dec_dest_rd = 1'b0; dec_branch = 1'b0; dec_j = 1'b0; dec_lw = 1'b0; dec_sw = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_use_imm = 1'b0;
        dec_dest_rd = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: dec_op = ALU_ADD;
          FN_SUB, FN_SUBU: dec_op = ALU_SUB;
          FN_AND:  dec_op = ALU_AND;
          FN_OR:   dec_op = ALU_OR;
          FN_XOR:  dec_op = ALU_XOR;
          FN_NOR:  dec_op = ALU_NOR;
          FN_SLT:  begin dec_op = ALU_SLT;  dec_legal = EN_SLT; end
          FN_SLTU: begin dec_op = ALU_SLTU; dec_legal = EN_SLT; end
          default: dec_legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: dec_op = ALU_ADD;
      OP_SLTI: begin dec_op = ALU_SLT; dec_legal = EN_SLT; end
      OP_ANDI: begin dec_op = ALU_AND; dec_zext = 1'b1; end
      OP_ORI:  begin dec_op = ALU_OR;  dec_zext = 1'b1; end
      OP_LUI:  begin dec_op = ALU_LUI; dec_zext = 1'b1; end
      OP_LW:   dec_lw = 1'b1;
      OP_SW:   dec_sw = 1'b1;
      OP_BEQ, OP_BNE: begin dec_op = ALU_SUB; dec_use_imm = 1'b0; dec_branch = 1'b1; end
      OP_J:    dec_j = 1'b1;
      default: dec_legal = 1'b0;
    endcase
  end

  assign alu_b = dec_use_imm ? (dec_zext ? imm_zext : imm_sext) : b_q;

  mips_alu u_alu (.op(dec_op), .a(a_q), .b(alu_b), .y(alu_y), .zero(alu_zero));

  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_we;

  assign rf_waddr = dec_dest_rd ? rd : rt;
  assign rf_wdata = dec_lw ? mdr_q : alu_q;
  assign rf_we    = (state_q == S_WB) && (rf_waddr != 5'd0);

  always_comb begin
    state_d = state_q;  pc_d = pc_q;  ir_d = ir_q;  a_d = a_q;  b_d = b_q;
    alu_d = alu_q;  mdr_d = mdr_q;  data_out_d = data_out_q;
    inst_addr_d = inst_addr_q;  data_addr_d = data_addr_q;
    inst_req_d = inst_req_q;  data_req_d = data_req_q;  data_wr_d = data_wr_q;
    retire_d = 1'b0;
    case (state_q)
      S_FETCH: if (inst_req_q && inst_ready) begin
        ir_d       = inst;
        pc_d       = pc_q + 32'd4;
        inst_req_d = 1'b0;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        a_d     = rf_q[rs];
        b_d     = rf_q[rt];
        state_d = dec_legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        alu_d = alu_y;
        if (dec_branch) begin
          if ((opcode == OP_BEQ) == alu_zero) pc_d = pc_q + {imm_sext[29:0], 2'b00};
          retire_d = 1'b1;
          state_d  = S_FETCH;
        end else if (dec_j) begin
          pc_d     = {pc_q[31:28], ir_q[25:0], 2'b00};
          retire_d = 1'b1;
          state_d  = S_FETCH;
        end else if (dec_lw || dec_sw) begin
          if (alu_y[1:0] != 2'b00) begin
            state_d = S_TRAP;
          end else begin
            data_req_d  = 1'b1;
            data_wr_d   = dec_sw;
            data_addr_d = alu_y[ADDR_W-1:0];
            data_out_d  = b_q;
            state_d     = S_MEM;
          end
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: if (data_req_q && data_ready) begin
        data_req_d = 1'b0;
        data_wr_d  = 1'b0;
        mdr_d      = data_in;
        retire_d   = dec_sw;
        state_d    = dec_sw ? S_FETCH : S_WB;
      end
      S_WB: begin
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
    // Entering FETCH presents the new PC together with the request in the same cycle.
    if (state_d == S_FETCH && state_q != S_FETCH) begin
      inst_req_d  = 1'b1;
      inst_addr_d = pc_d[ADDR_W-1:0];
    end else if (state_q == S_FETCH && state_d == S_FETCH) begin
      inst_req_d  = 1'b1;
      inst_addr_d = pc_q[ADDR_W-1:0];
    end
    trap_d = trap_q | (state_d == S_TRAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;  pc_q <= RESET_PC;  ir_q <= '0;  a_q <= '0;  b_q <= '0;
      alu_q <= '0;  mdr_q <= '0;  data_out_q <= '0;  inst_addr_q <= '0;  data_addr_q <= '0;
      inst_req_q <= 1'b0;  data_req_q <= 1'b0;  data_wr_q <= 1'b0;
      retire_q <= 1'b0;  trap_q <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;  pc_q <= pc_d;  ir_q <= ir_d;  a_q <= a_d;  b_q <= b_d;
      alu_q <= alu_d;  mdr_q <= mdr_d;  data_out_q <= data_out_d;
      inst_addr_q <= inst_addr_d;  data_addr_q <= data_addr_d;
      inst_req_q <= inst_req_d;  data_req_q <= data_req_d;  data_wr_q <= data_wr_d;
      retire_q <= retire_d;  trap_q <= trap_d;
      if (rf_we) rf_q[rf_waddr] <= rf_wdata;
    end
  end

  assign inst_req  = inst_req_q;
  assign inst_addr = inst_addr_q;
  assign data_req  = data_req_q;
  assign data_wr   = data_wr_q;
  assign data_addr = data_addr_q;
  assign data_out  = data_out_q;
  assign retire    = retire_q;
  assign trap      = trap_q;

endmodule

// File: tb/tb_multi_cycle_mips.sv
// Directed bench for multi_cycle_mips: small instruction/data memory models with programmable
// data wait states, register values observed through stores, latencies measured retire-to-retire.
module tb_multi_cycle_mips;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_req, data_req, data_wr, retire, trap;
  logic [31:0] inst_addr, data_addr, data_out;
  logic [31:0] inst = '0, data_in = '0;
  logic        inst_ready = 1'b0, data_ready = 1'b0;

  multi_cycle_mips dut (
    .clk(clk), .rst_n(rst_n),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst(inst), .inst_ready(inst_ready),
    .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr), .data_out(data_out),
    .data_in(data_in), .data_ready(data_ready),
    .retire(retire), .trap(trap)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [128];
  logic [31:0] dmem [64];
  int vectors = 0, errors = 0;
  int dwait = 0, dcnt = 0, stab_err = 0, ret_cnt = 0, st_cnt = 0, ireq_cnt = 0, dreq_cnt = 0;
  logic [31:0] held_addr = '0, last_st_addr = '0, last_st_data = '0;
  logic        held_wr = 1'b0;

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs after the edge, then drive memory responses for the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (retire) ret_cnt++;
    if (inst_req) ireq_cnt++;
    inst       = imem[inst_addr[8:2]];
    inst_ready = inst_req;
    if (data_req) begin
      dreq_cnt++;
      if (dcnt == 0) begin
        held_addr = data_addr;
        held_wr   = data_wr;
      end else if (data_addr !== held_addr || data_wr !== held_wr) begin
        stab_err++;
      end
      dcnt++;
      data_ready = (dcnt == dwait + 1);
      data_in    = dmem[data_addr[7:2]];
      if (data_ready && data_wr) begin
        dmem[data_addr[7:2]] = data_out;
        st_cnt++;
        last_st_addr = data_addr;
        last_st_data = data_out;
      end
    end else begin
      dcnt       = 0;
      data_ready = 1'b0;
    end
  endtask

  task automatic retire_wait(input string tag, output int cyc);
    int start;
    start = ret_cnt;
    cyc   = 0;
    while (ret_cnt == start && cyc < 60) begin
      tick();
      cyc++;
    end
    if (ret_cnt == start) begin
      vectors++;
      errors++;
      $error("FAIL %s: no retire within %0d cycles, expected one", tag, cyc);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 128; i++) imem[i] = 32'hFC00_0000;
  endtask

  // Pulses reset for two edges; returns just after the first edge following release.
  task automatic do_reset();
    rst_n = 1'b0;
    dwait = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, c1, c2, c3, r0, s0;
    logic [31:0] exp_d [5];

    for (int i = 0; i < 64; i++) dmem[i] = 32'h0;

    // Program A: arithmetic, store/load with wait states, branch self-loop.
    clear_imem();
    imem[0] = enc_i(6'h08, 5'd1, 5'd0, 16'd5);
    imem[1] = enc_i(6'h08, 5'd2, 5'd0, 16'hFFFD);
    imem[2] = enc_r(6'h20, 5'd3, 5'd1, 5'd2);
    imem[3] = enc_i(6'h2B, 5'd3, 5'd0, 16'd8);
    imem[4] = enc_i(6'h23, 5'd4, 5'd0, 16'd8);
    imem[5] = enc_i(6'h2B, 5'd4, 5'd0, 16'd12);
    imem[6] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);

    tick(); tick(); tick();
    check("rst_ctrl", 32'({inst_req, data_req, data_wr, retire, trap}), 32'h0);
    check("rst_inst_addr", inst_addr, 32'h0);
    check("rst_data_addr", data_addr, 32'h0);
    check("rst_data_out", data_out, 32'h0);
    rst_n = 1'b1;
    tick();
    check("first_inst_req", 32'(inst_req), 32'h1);
    check("first_inst_addr", inst_addr, 32'h0);

    retire_wait("addi1", c1);
    retire_wait("addi2", c2);
    retire_wait("add", c3);
    check("alu3_cycles", 32'(c1 + c2 + c3), 32'd12);
    check("addi_cycles", 32'(c1), 32'd4);

    dwait = 3;
    retire_wait("sw_wait", c);
    check("sw_wait_cycles", 32'(c), 32'd7);
    check("sw_addr", last_st_addr, 32'd8);
    check("sw_data_add", last_st_data, 32'd2);
    check("sw_addr_stable", 32'(stab_err), 32'd0);
    retire_wait("lw_wait", c);
    check("lw_wait_cycles", 32'(c), 32'd8);
    check("lw_addr_stable", 32'(stab_err), 32'd0);
    dwait = 0;
    retire_wait("sw_lw_result", c);
    check("sw_zero_wait_cycles", 32'(c), 32'd4);
    check("sw_lw_data", last_st_data, 32'd2);
    check("sw_lw_addr", last_st_addr, 32'd12);
    check("store_count", 32'(st_cnt), 32'd2);

    retire_wait("beq1", c);
    check("beq_cycles", 32'(c), 32'd3);
    check("beq_loop_addr1", inst_addr, 32'd24);
    retire_wait("beq2", c);
    check("beq_loop_addr2", inst_addr, 32'd24);

    // Program B: untaken bne, jump, then an illegal opcode at the jump target.
    clear_imem();
    imem[0]  = enc_i(6'h08, 5'd1, 5'd0, 16'd1);
    imem[1]  = enc_i(6'h05, 5'd1, 5'd1, 16'd5);
    imem[2]  = {6'h02, 26'h40};
    do_reset();
    check("b_restart_addr", inst_addr, 32'h0);
    retire_wait("b_addi", c);
    retire_wait("bne", c);
    check("bne_cycles", 32'(c), 32'd3);
    check("bne_fallthrough", inst_addr, 32'd8);
    retire_wait("j", c);
    check("j_cycles", 32'(c), 32'd3);
    check("j_target", inst_addr, 32'h100);
    for (int i = 0; i < 10 && !trap; i++) tick();
    check("illegal_trap", 32'(trap), 32'h1);
    ireq_cnt = 0;
    r0 = ret_cnt;
    repeat (10) tick();
    check("trap_no_fetch", 32'(ireq_cnt), 32'd0);
    check("trap_no_retire", 32'(ret_cnt - r0), 32'd0);
    check("trap_sticky", 32'(trap), 32'h1);

    // Program C: misaligned load traps without a data request or writeback.
    clear_imem();
    imem[0] = enc_i(6'h08, 5'd5, 5'd0, 16'd9);
    imem[1] = enc_i(6'h2B, 5'd5, 5'd0, 16'd0);
    imem[2] = enc_i(6'h23, 5'd5, 5'd0, 16'd2);
    do_reset();
    check("c_trap_cleared", 32'(trap), 32'h0);
    retire_wait("c_addi", c);
    retire_wait("c_sw", c);
    check("c_sw_data", last_st_data, 32'd9);
    dreq_cnt = 0;
    r0 = ret_cnt;
    for (int i = 0; i < 10 && !trap; i++) tick();
    check("misaligned_trap", 32'(trap), 32'h1);
    check("misaligned_no_req", 32'(dreq_cnt), 32'd0);
    check("misaligned_no_retire", 32'(ret_cnt - r0), 32'd0);

    // Program D: $0 semantics, slt/sltu, zero-extended ori, lui, then reset during a MEM wait.
    clear_imem();
    imem[0]  = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
    imem[1]  = enc_r(6'h20, 5'd6, 5'd0, 5'd0);
    imem[2]  = enc_i(6'h08, 5'd2, 5'd0, 16'hFFFD);
    imem[3]  = enc_i(6'h0D, 5'd1, 5'd0, 16'h8005);
    imem[4]  = enc_r(6'h2A, 5'd8, 5'd2, 5'd1);
    imem[5]  = enc_r(6'h2B, 5'd9, 5'd2, 5'd1);
    imem[6]  = enc_i(6'h0F, 5'd10, 5'd0, 16'h1234);
    imem[7]  = enc_i(6'h2B, 5'd6, 5'd0, 16'd4);
    imem[8]  = enc_i(6'h2B, 5'd8, 5'd0, 16'd8);
    imem[9]  = enc_i(6'h2B, 5'd9, 5'd0, 16'd12);
    imem[10] = enc_i(6'h2B, 5'd1, 5'd0, 16'd16);
    imem[11] = enc_i(6'h2B, 5'd10, 5'd0, 16'd20);
    imem[12] = enc_i(6'h2B, 5'd6, 5'd0, 16'd24);
    exp_d = '{32'h0, 32'h1, 32'h0, 32'h0000_8005, 32'h1234_0000};
    do_reset();
    for (int i = 0; i < 7; i++) retire_wait("d_alu", c);
    for (int i = 0; i < 5; i++) begin
      retire_wait("d_sw", c);
      check($sformatf("d_store_data%0d", i), last_st_data, exp_d[i]);
      check($sformatf("d_store_addr%0d", i), last_st_addr, 32'(4 * (i + 1)));
    end

    dwait = 10;
    for (int i = 0; i < 10 && !data_req; i++) tick();
    repeat (2) tick();
    check("mem_wait_req", 32'(data_req), 32'h1);
    check("mem_wait_addr", data_addr, 32'd24);
    s0 = st_cnt;
    rst_n = 1'b0;
    #1;
    check("async_req_drop", 32'(data_req), 32'h0);
    check("async_addr_clear", data_addr, 32'h0);
    check("async_retire_low", 32'(retire), 32'h0);
    dwait = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("restart_req", 32'(inst_req), 32'h1);
    check("restart_addr", inst_addr, 32'h0);
    check("aborted_store", 32'(st_cnt - s0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
